// File: rtl/flash_reader_pkg.sv
// Shared types and constants for the serial-flash read controller.
package flash_reader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCommand,
    StAddress,
    StDummy,
    StData,
    StDeselect
  } state_e;

  localparam logic [7:0]  ReadCmd     = 8'h03;
  localparam logic [7:0]  FastReadCmd = 8'h0B;
  localparam int unsigned CmdBits     = 8;
  localparam int unsigned AddrBits    = 24;
  localparam int unsigned DummyClocks = 8;

endpackage

// File: rtl/flash_sclk_gen.sv
// SPI clock divider: flash_clk half-period of ClkDivider cycles, with rise/fall
// strobes asserted in the cycle before the corresponding edge. Stall freezes the low phase.
module flash_sclk_gen #(
  parameter int unsigned ClkDivider = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic stall,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int unsigned CntW = (ClkDivider > 1) ? $clog2(ClkDivider) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(ClkDivider - 1);

  logic [CntW-1:0] cnt;
  logic            hold;
  logic            tick;

  always_comb begin
    hold = stall && !sclk;
    tick = en && !hold && (cnt == CntLast);
    rise = tick && !sclk;
    fall = tick && sclk;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!hold) begin
      if (cnt == CntLast) begin
        cnt  <= '0;
        sclk <= !sclk;
      end else begin
        cnt <= cnt + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/flash_reader.sv
// SPI mode-0 burst reader for the serial boot flash with a single-byte output register.
// Define FLASH_READER_FAST_READ_EN to use opcode 0x0B with 8 dummy clocks.
module flash_reader
  import flash_reader_pkg::*;
#(
  parameter int unsigned ClkDivider   = 1,
  parameter int unsigned CsHighCycles = 4,
  parameter int unsigned LenBitwidth  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [23:0]            req_addr,
  input  logic [LenBitwidth-1:0] req_len,
  output logic                   data_valid,
  input  logic                   data_ready,
  output logic [7:0]             data,
  output logic                   busy,
  output logic                   flash_clk,
  output logic                   flash_mosi,
  output logic                   flash_cs_n,
  input  logic                   flash_miso
);

`ifdef FLASH_READER_FAST_READ_EN
  localparam logic [7:0] Opcode = FastReadCmd;
`else
  localparam logic [7:0] Opcode = ReadCmd;
`endif
  localparam int unsigned CsW = $clog2(CsHighCycles + 1);

  state_e                 state, state_next;
  logic [4:0]             bit_cnt;
  logic [31:0]            tx_sr;
  logic [7:0]             rx_sr;
  logic [LenBitwidth-1:0] remaining;
  logic                   pending;
  logic [CsW-1:0]         cs_cnt;
  logic                   sclk_en, rise, fall;
  logic                   out_free, load, stall;

  flash_sclk_gen #(
    .ClkDivider(ClkDivider)
  ) u_sclk (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (sclk_en),
    .stall(stall),
    .sclk (flash_clk),
    .rise (rise),
    .fall (fall)
  );

  // A completed byte waits in rx_sr; it moves out on the falling edge, or later
  // once the output register frees, and the next rising edge is held off until then.
  assign out_free   = !data_valid || data_ready;
  assign load       = pending && out_free && (fall || !flash_clk);
  assign stall      = pending && !out_free;
  assign flash_mosi = tx_sr[31];
  assign busy       = !req_ready;

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    sclk_en    = 1'b0;
    case (state)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid && req_len != '0) state_next = StCommand;
      end
      StCommand: begin
        sclk_en = 1'b1;
        if (rise && bit_cnt == 5'(CmdBits - 1)) state_next = StAddress;
      end
      StAddress: begin
        sclk_en = 1'b1;
`ifdef FLASH_READER_FAST_READ_EN
        if (rise && bit_cnt == 5'(AddrBits - 1)) state_next = StDummy;
`else
        if (rise && bit_cnt == 5'(AddrBits - 1)) state_next = StData;
`endif
      end
`ifdef FLASH_READER_FAST_READ_EN
      StDummy: begin
        sclk_en = 1'b1;
        if (rise && bit_cnt == 5'(DummyClocks - 1)) state_next = StData;
      end
`endif
      StData: begin
        sclk_en = 1'b1;
        if (fall && remaining == '0) state_next = StDeselect;
      end
      StDeselect: begin
        if (cs_cnt >= CsW'(CsHighCycles - 1) && !pending && !data_valid)
          state_next = StIdle;
      end
      default: state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      bit_cnt    <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      remaining  <= '0;
      pending    <= 1'b0;
      data_valid <= 1'b0;
      data       <= '0;
      flash_cs_n <= 1'b1;
      cs_cnt     <= '0;
    end else begin
      state <= state_next;

      if (state == StIdle) begin
        bit_cnt <= '0;
        if (req_valid && req_len != '0) begin
          tx_sr      <= {Opcode, req_addr};
          remaining  <= req_len;
          flash_cs_n <= 1'b0;
        end
      end

      if (fall) tx_sr <= {tx_sr[30:0], 1'b0};

      if (rise) begin
        if (state_next != state || (state == StData && bit_cnt == 5'd7)) bit_cnt <= '0;
        else                                                              bit_cnt <= bit_cnt + 5'd1;
        if (state == StData) begin
          rx_sr <= {rx_sr[6:0], flash_miso};
          if (bit_cnt == 5'd7) begin
            pending   <= 1'b1;
            remaining <= remaining - LenBitwidth'(1);
          end
        end
      end

      if (load) begin
        pending    <= 1'b0;
        data       <= rx_sr;
        data_valid <= 1'b1;
      end else if (data_ready) begin
        data_valid <= 1'b0;
      end

      if (state == StDeselect) begin
        flash_cs_n <= 1'b1;
        if (cs_cnt != '1) cs_cnt <= cs_cnt + CsW'(1);
      end else begin
        cs_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_flash_reader.sv
// Scoreboard bench for flash_reader with a behavioural SPI flash (byte at address a is a[7:0]).
`timescale 1ns/1ps
module tb_flash_reader;

  localparam int unsigned ClkDiv = 3;
  localparam int unsigned CsHigh = 4;
  localparam int unsigned LenW   = 16;
`ifdef FLASH_READER_FAST_READ_EN
  localparam logic [7:0]  ExpOpcode = 8'h0B;
  localparam int unsigned HdrBits   = 40;
`else
  localparam logic [7:0]  ExpOpcode = 8'h03;
  localparam int unsigned HdrBits   = 32;
`endif
  localparam int unsigned FirstLat = 1 + 2 * ClkDiv * (HdrBits + 8);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [23:0]     req_addr = '0;
  logic [LenW-1:0] req_len = '0;
  logic            data_valid;
  logic            data_ready = 1'b0;
  logic [7:0]      data;
  logic            busy;
  logic            flash_clk, flash_mosi, flash_cs_n;
  logic            flash_miso = 1'b0;

  flash_reader #(
    .ClkDivider  (ClkDiv),
    .CsHighCycles(CsHigh),
    .LenBitwidth (LenW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .data      (data),
    .busy      (busy),
    .flash_clk (flash_clk),
    .flash_mosi(flash_mosi),
    .flash_cs_n(flash_cs_n),
    .flash_miso(flash_miso)
  );

  initial forever #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned errors  = 0;
  int unsigned cyc     = 0;
  int unsigned cons_mode = 0;
  bit          in_reset  = 1'b0;

  logic [7:0]  exp_q[$];
  int unsigned lat_q[$];
  int unsigned len_q[$];
  logic [23:0] hdr_addr_q[$];
  int unsigned hdr_len_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural flash: captures command/address on rising edges, shifts data out on falling edges.
  int unsigned f_rises = 0;
  logic [31:0] f_hdr   = '0;
`ifdef FLASH_READER_FAST_READ_EN
  int unsigned f_dummy_ones = 0;
`endif

  always @(posedge flash_clk or posedge flash_cs_n) begin
    if (flash_cs_n) begin
      if (f_rises != 0 && !in_reset) begin
        if (hdr_addr_q.size() == 0) begin
          check("unexpected_transfer", f_rises, 0);
        end else begin
          logic [23:0] ea;
          int unsigned el;
          ea = hdr_addr_q.pop_front();
          el = hdr_len_q.pop_front();
          check("opcode", {24'h0, f_hdr[31:24]}, {24'h0, ExpOpcode});
          check("address", {8'h0, f_hdr[23:0]}, {8'h0, ea});
          check("sclk_rise_count", f_rises, HdrBits + 8 * el);
`ifdef FLASH_READER_FAST_READ_EN
          check("dummy_mosi_zero", f_dummy_ones, 0);
`endif
        end
      end
      f_rises = 0;
      f_hdr   = '0;
`ifdef FLASH_READER_FAST_READ_EN
      f_dummy_ones = 0;
`endif
    end else begin
      if (f_rises < 32) f_hdr = {f_hdr[30:0], flash_mosi};
`ifdef FLASH_READER_FAST_READ_EN
      else if (f_rises < HdrBits && flash_mosi) f_dummy_ones++;
`endif
      f_rises++;
    end
  end

  always @(negedge flash_clk) begin
    if (!flash_cs_n && f_rises >= HdrBits) begin
      int unsigned d;
      logic [23:0] fa;
      d  = f_rises - HdrBits;
      fa = f_hdr[23:0] + 24'(d / 8);
      flash_miso = fa[7 - (d % 8)];
    end
  end

  // Consumer
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (cons_mode)
        0:       data_ready = 1'b1;
        1:       data_ready = ($urandom_range(0, 3) != 0);
        default: data_ready = 1'b0;
      endcase
    end
  end

  // Monitor
  int unsigned cur_left = 0, hi_run = 0, stall_run = 0, cs_hi = CsHigh;
  always @(negedge clk) begin
    if (!rst_n) begin
      cur_left  = 0;
      hi_run    = 0;
      stall_run = 0;
      cs_hi     = CsHigh;
    end else begin
      check("busy_is_not_ready", {31'h0, busy}, {31'h0, !req_ready});
      if (data_valid && cur_left == 0) begin
        if (lat_q.size() == 0) begin
          check("unexpected_byte", {31'h0, data_valid}, 0);
        end else begin
          check("first_byte_cycle", cyc, lat_q.pop_front());
          cur_left = len_q.pop_front();
        end
      end
      if (data_valid && data_ready) begin
        if (exp_q.size() == 0) check("extra_byte", {24'h0, data}, 32'hFFFF_FFFF);
        else                   check("data", {24'h0, data}, {24'h0, exp_q.pop_front()});
        if (cur_left != 0) cur_left--;
      end
      if (data_valid && !data_ready) stall_run++;
      else                           stall_run = 0;
      if (stall_run > 16 * ClkDiv + 2) check("sclk_frozen_low", {31'h0, flash_clk}, 0);
      if (flash_clk) hi_run++;
      else begin
        if (hi_run != 0) check("sclk_high_phase", hi_run, ClkDiv);
        hi_run = 0;
      end
      if (flash_cs_n) cs_hi++;
      else begin
        if (cs_hi != 0) check("cs_high_min", {31'h0, cs_hi >= CsHigh}, 1);
        cs_hi = 0;
      end
    end
  end

  task automatic issue(input logic [23:0] a, input int unsigned l, input bit junk);
    int unsigned guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    check("req_ready_wait", {31'h0, req_ready}, 1);
    if (!req_ready) return;
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = LenW'(l);
    if (l != 0) begin
      for (int unsigned i = 0; i < l; i++) begin
        logic [23:0] ba;
        ba = a + 24'(i);
        exp_q.push_back(ba[7:0]);
      end
      lat_q.push_back(cyc + FirstLat);
      len_q.push_back(l);
      hdr_addr_q.push_back(a);
      hdr_len_q.push_back(l);
    end
    @(negedge clk);
    if (junk && l != 0) begin
      repeat (20) begin
        req_addr = 24'($urandom);
        req_len  = LenW'($urandom);
        check("busy_during_transfer", {31'h0, busy}, 1);
        @(negedge clk);
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int unsigned guard = 0;
    while (!(req_ready && exp_q.size() == 0 && flash_cs_n) && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    check("drain_done", {31'h0, req_ready && exp_q.size() == 0}, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #12;
    check("rst_req_ready", {31'h0, req_ready}, 1);
    check("rst_busy", {31'h0, busy}, 0);
    check("rst_data_valid", {31'h0, data_valid}, 0);
    check("rst_data", {24'h0, data}, 0);
    check("rst_flash_clk", {31'h0, flash_clk}, 0);
    check("rst_flash_mosi", {31'h0, flash_mosi}, 0);
    check("rst_flash_cs_n", {31'h0, flash_cs_n}, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Basic burst
    cons_mode = 0;
    issue(24'h000010, 4, 1'b0);
    wait_done();

    // Zero length: no bus activity
    issue(24'h123456, 0, 1'b0);
    repeat (20) begin
      check("len0_cs_n", {31'h0, flash_cs_n}, 1);
      check("len0_sclk", {31'h0, flash_clk}, 0);
      check("len0_ready", {31'h0, req_ready}, 1);
      @(negedge clk);
    end

    // Long backpressure after first byte
    cons_mode = 2;
    issue(24'h0A2345, 3, 1'b0);
    begin
      int unsigned guard = 0;
      while (!data_valid && guard < 5000) begin
        @(negedge clk);
        guard++;
      end
      check("stall_first_valid", {31'h0, data_valid}, 1);
    end
    repeat (100) @(negedge clk);
    cons_mode = 0;
    wait_done();

    // Reset in the middle of the address phase
    issue(24'h55AA33, 5, 1'b0);
    repeat (1 + ClkDiv + 2 * ClkDiv * 16) @(negedge clk);
    check("pre_abort_cs_low", {31'h0, flash_cs_n}, 0);
    @(posedge clk);
    #1;
    in_reset = 1'b1;
    rst_n = 1'b0;
    #1;
    check("abort_cs_n", {31'h0, flash_cs_n}, 1);
    check("abort_sclk", {31'h0, flash_clk}, 0);
    check("abort_ready", {31'h0, req_ready}, 1);
    exp_q.delete();
    lat_q.delete();
    len_q.delete();
    hdr_addr_q.delete();
    hdr_len_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    in_reset = 1'b0;
    issue(24'h000200, 2, 1'b0);
    wait_done();

`ifdef FLASH_READER_FAST_READ_EN
    issue(24'h000100, 2, 1'b0);
    wait_done();
`endif

    // Wrap at the top of the address space
    cons_mode = 1;
    issue(24'hFFFFFE, 4, 1'b1);

    // Randomised bursts with random backpressure
    for (int unsigned n = 0; n < 12; n++) begin
      int unsigned l;
      l = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 5);
      cons_mode = $urandom_range(0, 1);
      issue(24'($urandom), l, 1'b1);
      repeat ($urandom_range(0, 10)) @(negedge clk);
    end
    cons_mode = 0;
    wait_done();
    check("scoreboard_empty", exp_q.size() + lat_q.size() + hdr_addr_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/flash_reader.md
# flash_reader

SPI read-controller that fetches a burst of bytes from the on-board serial flash (P25Q32U-class) and streams them to the core. A requester supplies a 24-bit start address and byte count through a valid/ready handshake; the block drives chip-select, serial clock and command/address bits (SPI mode 0), shifts in data and presents it one byte at a time with backpressure. It sits between the boot loader / ROM-shadow logic and the flash pins.

## Interface
- ClkDivider, 1: half-period of flash_clk in clk cycles (≥1).
- CsHighCycles, 4: minimum cycles flash_cs_n stays high between transfers (≥1).
- LenBitwidth, 16: width of req_len.
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  1  burst request valid.
- req_ready  output  1  block idle, request accepted when req_valid && req_ready.
- req_addr  input  24  flash byte address of first byte.
- req_len  input  LenBitwidth  bytes to read; 0 = accepted, no bus activity.
- data_valid  output  1  data holds a byte.
- data_ready  input  1  consumer takes byte when data_valid && data_ready.
- data  output  8  received byte.
- busy  output  1  transfer in progress (complement of req_ready).
- flash_clk  output  1  SPI clock, idle low.
- flash_mosi  output  1  command/address bits, MSB first.
- flash_cs_n  output  1  chip select, active-low.
- flash_miso  input  1  data from flash.

## Operation
- Reset values: req_ready=1, busy=0, data_valid=0, data=0, flash_clk=0, flash_mosi=0, flash_cs_n=1. Reset mid-transfer aborts immediately; cs_n high asynchronously.
- States: Idle → Command → Address → [Dummy] → Data → Deselect → Idle.
- Idle: on accept, latch addr/len; len=0 stays Idle (req_ready remains 1); otherwise flash_cs_n=0 next cycle, enter Command.
- Command: 8 bits of 0x03 (0x0B with FLASH_READER_FAST_READ_EN). Address: 24 bits, MSB first. Dummy: 8 clocks, mosi=0.
- mosi changes only while flash_clk low; first bit valid one half-period before first rising edge.
- Data: miso sampled on each rising flash_clk edge, MSB first; after 8th bit the byte moves to the output register, data_valid=1, remaining count decrements.
- Backpressure: one output register only. If the next byte completes while data_valid && !data_ready, flash_clk holds low (stalls) until the register frees; no byte lost or duplicated.
- After last byte's 8th rising edge: flash_clk returns low, then flash_cs_n=1; Deselect holds CsHighCycles cycles and until last byte consumed; then req_ready=1.
- Count arithmetic unsigned, LenBitwidth wide; address is not incremented by the block (flash auto-increments; wrap at 0xFFFFFF handled by flash).
- req_valid while busy is ignored (req_ready=0).

## Timing
- flash_clk period 2*ClkDivider clk cycles; rising edge and miso sample on the same clk edge.
- Accept at cycle 0 → flash_cs_n low at cycle 1 → first rising edge at 1+ClkDivider.
- Without stall, first data_valid at cycle 1 + 2*ClkDivider*40 (ClkDivider=1: cycle 81); with fast read +16*ClkDivider.
- Subsequent bytes every 16*ClkDivider cycles if consumer always ready.
- data_valid deasserts cycle after acceptance unless a new byte loads the same cycle (back-to-back holds 1).

## Configuration
- FLASH_READER_FAST_READ_EN defined: opcode 0x0B plus 8 dummy clocks after address (Dummy state present). Undefined: opcode 0x03, no Dummy state.

## Structure
- flash_reader_pkg: state_e enum, opcode constants (ReadCmd=8'h03, FastReadCmd=8'h0B), AddrBits=24, DummyClocks=8.
- Sub-module flash_sclk_gen: divider producing rise/fall strobes, with stall input gating flash_clk.

## Test plan
- Flash data[i]=i[7:0]; req addr=0x000010 len=4, data_ready=1 → bytes 0x10,0x11,0x12,0x13; mosi stream 0x03,0x000010; cs_n high after; req_ready after CsHighCycles.
- req_len=0 → no cs_n/flash_clk activity, req_ready stays 1.
- len=3, data_ready=0 for 100 cycles after first byte → flash_clk frozen low, then 0x..,+1,+2 exactly once each.
- ClkDivider=3, len=1 → flash_clk period 6 cycles; first data_valid at cycle 241.
- rst_n low mid-address phase → cs_n=1, flash_clk=0 same cycle; new request afterwards reads correctly.
- FLASH_READER_FAST_READ_EN, addr=0x000100 len=2 → opcode 0x0B, 8 dummy clocks, bytes 0x00,0x01.
